cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control FSM that sequences the cpu_module datapath through fetch, decode, execute, memory and writeback phases. It handshakes with instruction and data memory, and drives the program-counter increment/load pulses and the register-file write strobe. It also counts retired instructions and traps on halt, illegal opcode class or memory timeout.

Parameters:
CNT_W, 16, width of the retired-instruction counter (saturating).
TIMEOUT, 16, maximum cycles a memory request waits for ack before ERROR (>=1).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  leave IDLE and begin fetching; ignored in all other states.
imem_req  output  1  instruction fetch request; held high until imem_ack.
imem_ack  input  1  instruction memory ack; instruction valid on din this cycle.
ir_we  output  1  instruction register capture strobe.
op_class  input  3  decoder class, sampled in DECODE/EXECUTE: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6-7 illegal.
branch_taken  input  1  ALU compare result, sampled in EXECUTE.
alu_en  output  1  ALU operand/result register enable.
dmem_req  output  1  data memory request; held until dmem_ack.
dmem_we  output  1  data memory write (STORE), valid while dmem_req.
dmem_ack  input  1  data memory ack.
rf_we  output  1  register file write strobe.
pc_inc  output  1  PC <= PC+4 pulse.
pc_load  output  1  PC <= target pulse.
halted  output  1  high while in HALT.
error  output  1  high while in ERROR.
state  output  3  current state encoding, debug.
retired  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous, edge where reset=1): state=IDLE, retired=0, wait counter=0. All strobes, requests, halted and error are 0 from the next cycle. Reset overrides every other input, mid-transaction included; outstanding memory requests are dropped.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Outputs are combinational from state plus the listed inputs. Every strobe is high for exactly one cycle per instruction.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH: imem_req=1.
  - imem_ack=1: ir_we=1 in the same cycle -> DECODE.
  - Otherwise stay.
- DECODE:
  - op_class 5 -> HALT.
  - op_class 6/7 -> ERROR.
  - Otherwise -> EXECUTE.
- EXECUTE: alu_en=1. Action by op_class:
  - ALU -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: pc_load=branch_taken, pc_inc=~branch_taken; retire; -> FETCH.
  - JUMP: pc_load=1, rf_we=1 (link); retire; -> FETCH.
- MEM: dmem_req=1, dmem_we=(op_class==STORE).
  - On dmem_ack, STORE: pc_inc=1, retire, -> FETCH.
  - On dmem_ack, LOAD: -> WB.
- WB: rf_we=1, pc_inc=1, retire -> FETCH.
- HALT/ERROR: terminal; only reset exits. start is ignored.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle that the req is high and ack is low.
  - If ack is low when the counter equals TIMEOUT-1 -> ERROR. Ack is therefore accepted in any of the first TIMEOUT cycles of a request.
  - Ack arriving in the same cycle as the timeout check wins.
- Retire: retired += 1, saturating at all-ones. HALT is not counted.
- op_class is held stable by the decoder from DECODE through the end of the instruction.
- Latency with zero-wait memory: ALU/LOAD 4/5 cycles, STORE 4, BRANCH/JUMP 3 cycles from FETCH entry to the next FETCH.
- Acks outside the matching request state are ignored.

Decomposition:
- Package cpu_ctrl_pkg: state encodings, op_class constants (OP_ALU..OP_HALT), and the TIMEOUT-derived counter width function.
- One sub-module, mem_wait_timer: clear/enable inputs, timeout output, TIMEOUT parameter. It is shared by FETCH and MEM.
- The FSM stays in cpu_sequencer.

Test Plan:
- Reset, then start=1, imem_ack=1 immediately, op_class=0 (ALU) -> ir_we in FETCH cycle; alu_en next-but-one; rf_we and pc_inc together in WB; retired=1 after 4 cycles; back in FETCH.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB rf_we=1, pc_inc=1, retired increments by 1. STORE -> dmem_we=1, no rf_we, pc_inc on ack cycle.
- BRANCH with branch_taken=1 then 0 -> pc_load=1/pc_inc=0, then pc_load=0/pc_inc=1, each from EXECUTE straight to FETCH. JUMP -> pc_load=1 and rf_we=1 in the same cycle.
- imem_ack held 0 with TIMEOUT=16 -> imem_req high exactly 16 cycles, then state=7, error=1 persisting. Ack on the 16th cycle -> no error, DECODE.
- op_class=5 -> state=6, halted=1, retired unchanged; start pulses ignored. op_class=7 -> error=1.
- Assert reset during MEM with dmem_req high -> next cycle state=0, dmem_req=0, retired=0. Preload retired near max via CNT_W=4 and run 20 ALU ops -> retired stays 15.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: state encodings,
// decoder op_class values and the wait-counter width helper.
package cpu_ctrl_pkg;

  // Controller states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  // Decoder instruction classes; 6 and 7 are illegal.
  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  // Bits needed to count 0..timeout-1 (at least one bit).
  function automatic int wait_cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-request wait counter shared by the fetch and data-memory phases.
// timeout is high while the counter sits on its last allowed cycle, so an
// ack can still be accepted in that cycle by the caller.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = wait_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  // Count waiting cycles; clear has priority and the count holds at LAST.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign timeout = (count_reg == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the cpu_module datapath. Sequences fetch,
// decode, execute, memory and writeback, handshakes with instruction and
// data memory, and counts retired instructions (saturating).
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic [2:0]       op_class,
  input  logic             branch_taken,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_reg;
  state_t           state_next;
  logic             retire;
  logic             timer_clear;
  logic             timer_en;
  logic             timed_out;
  logic [CNT_W-1:0] retired_reg;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .timeout(timed_out)
  );

  // Next-state and Mealy outputs: strobes depend on state plus handshake
  // inputs so that, e.g., ir_we coincides with the imem_ack cycle.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    halted     = 1'b0;
    error      = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (timed_out) begin
          state_next = ST_ERROR;
        end
      end
      ST_DECODE: begin
        case (op_class)
          OP_HALT:      state_next = ST_HALT;
          3'd6, 3'd7:   state_next = ST_ERROR;
          default:      state_next = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        alu_en = 1'b1;
        case (op_class)
          OP_ALU:           state_next = ST_WB;
          OP_LOAD, OP_STORE: state_next = ST_MEM;
          OP_BRANCH: begin
            pc_load    = branch_taken;
            pc_inc     = ~branch_taken;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          OP_JUMP: begin
            pc_load    = 1'b1;
            rf_we      = 1'b1;  // link register write
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          // Unreachable when op_class is held stable from DECODE.
          default:          state_next = ST_ERROR;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == OP_STORE);
        if (dmem_ack) begin
          if (op_class == OP_STORE) begin
            pc_inc     = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timed_out) begin
          state_next = ST_ERROR;
        end
      end
      ST_WB: begin
        rf_we      = 1'b1;
        pc_inc     = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_ERROR: error  = 1'b1;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Wait timer control: restart on entry to a request state, count while
  // a request is outstanding without ack.
  always_comb begin
    timer_clear = ((state_next == ST_FETCH) || (state_next == ST_MEM)) &&
                  (state_next != state_reg);
    timer_en    = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  end

  // State register; reset drops any outstanding request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_reg <= '0;
    end else if (retire && (retired_reg != {CNT_W{1'b1}})) begin
      retired_reg <= retired_reg + 1'b1;
    end
  end

  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: a per-cycle vector table for the
// instruction mix, plus hand-written timeout, illegal-op, reset and
// saturation sequences.
module tb_cpu_sequencer;

  // Strobe vector order: imem_req, ir_we, alu_en, dmem_req, dmem_we,
  // rf_we, pc_inc, pc_load, halted, error.
  localparam logic [9:0] S_IREQ = 10'b10_0000_0000;
  localparam logic [9:0] S_IRWE = 10'b01_0000_0000;
  localparam logic [9:0] S_ALU  = 10'b00_1000_0000;
  localparam logic [9:0] S_DREQ = 10'b00_0100_0000;
  localparam logic [9:0] S_DWE  = 10'b00_0010_0000;
  localparam logic [9:0] S_RFWE = 10'b00_0001_0000;
  localparam logic [9:0] S_PINC = 10'b00_0000_1000;
  localparam logic [9:0] S_PLD  = 10'b00_0000_0100;
  localparam logic [9:0] S_HLT  = 10'b00_0000_0010;
  localparam logic [9:0] S_ERR  = 10'b00_0000_0001;

  logic       clock;
  logic       reset;
  logic       start;
  logic       imem_req;
  logic       imem_ack;
  logic       ir_we;
  logic [2:0] op_class;
  logic       branch_taken;
  logic       alu_en;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic       rf_we;
  logic       pc_inc;
  logic       pc_load;
  logic       halted;
  logic       error;
  logic [2:0] state;
  logic [3:0] retired;

  int compared   = 0;
  int mismatched = 0;

  cpu_sequencer #(
    .CNT_W  (4),
    .TIMEOUT(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .ir_we       (ir_we),
    .op_class    (op_class),
    .branch_taken(branch_taken),
    .alu_en      (alu_en),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rf_we       (rf_we),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .halted      (halted),
    .error       (error),
    .state       (state),
    .retired     (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       s;
    logic       ia;
    logic [2:0] op;
    logic       bt;
    logic       da;
    logic [2:0] est;
    logic [9:0] estr;
    logic [3:0] eret;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic ia, input logic [2:0] op,
                              input logic bt, input logic da, input logic [2:0] est,
                              input logic [9:0] estr, input logic [3:0] eret);
    vec_t v;
    v.s = s; v.ia = ia; v.op = op; v.bt = bt; v.da = da;
    v.est = est; v.estr = estr; v.eret = eret;
    return v;
  endfunction

  // Drive one cycle of inputs, compare all outputs mid-cycle, advance.
  task automatic step(input logic s, input logic ia, input logic [2:0] op,
                      input logic bt, input logic da, input logic [2:0] est,
                      input logic [9:0] estr, input logic [3:0] eret,
                      input string nm);
    logic [9:0] got;
    start = s; imem_ack = ia; op_class = op; branch_taken = bt; dmem_ack = da;
    @(negedge clock);
    got = {imem_req, ir_we, alu_en, dmem_req, dmem_we,
           rf_we, pc_inc, pc_load, halted, error};
    compared++;
    if ({state, got, retired} !== {est, estr, eret}) begin
      mismatched++;
      $display("FAIL %s: got state=%0d strobes=%b retired=%0d, want state=%0d strobes=%b retired=%0d",
               nm, state, got, retired, est, estr, eret);
    end else begin
      $display("ok   %s: state=%0d strobes=%b retired=%0d", nm, state, got, retired);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; imem_ack = 1'b0; op_class = 3'd0; branch_taken = 1'b0; dmem_ack = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Instruction mix: ALU, LOAD (3 wait cycles), STORE, BRANCH taken,
    // BRANCH not taken, JUMP, stray dmem_ack in FETCH, HALT with start.
    vq.push_back(mk(1,0,0,0,0, 0, 10'd0,          0)); // IDLE start
    vq.push_back(mk(0,1,0,0,0, 1, S_IREQ|S_IRWE,  0)); // ALU fetch
    vq.push_back(mk(0,0,0,0,0, 2, 10'd0,          0));
    vq.push_back(mk(0,0,0,0,0, 3, S_ALU,          0));
    vq.push_back(mk(0,0,0,0,0, 5, S_RFWE|S_PINC,  0));
    vq.push_back(mk(0,1,1,0,0, 1, S_IREQ|S_IRWE,  1)); // LOAD fetch
    vq.push_back(mk(0,0,1,0,0, 2, 10'd0,          1));
    vq.push_back(mk(0,0,1,0,0, 3, S_ALU,          1));
    vq.push_back(mk(0,0,1,0,0, 4, S_DREQ,         1));
    vq.push_back(mk(0,0,1,0,0, 4, S_DREQ,         1));
    vq.push_back(mk(0,0,1,0,0, 4, S_DREQ,         1));
    vq.push_back(mk(0,0,1,0,1, 4, S_DREQ,         1));
    vq.push_back(mk(0,0,1,0,0, 5, S_RFWE|S_PINC,  1));
    vq.push_back(mk(0,1,2,0,0, 1, S_IREQ|S_IRWE,  2)); // STORE fetch
    vq.push_back(mk(0,0,2,0,0, 2, 10'd0,          2));
    vq.push_back(mk(0,0,2,0,0, 3, S_ALU,          2));
    vq.push_back(mk(0,0,2,0,1, 4, S_DREQ|S_DWE|S_PINC, 2));
    vq.push_back(mk(0,0,3,0,0, 1, S_IREQ,         3)); // BRANCH, 1 wait
    vq.push_back(mk(0,1,3,0,0, 1, S_IREQ|S_IRWE,  3));
    vq.push_back(mk(0,0,3,0,0, 2, 10'd0,          3));
    vq.push_back(mk(0,0,3,1,0, 3, S_ALU|S_PLD,    3));
    vq.push_back(mk(0,1,3,0,0, 1, S_IREQ|S_IRWE,  4)); // BRANCH not taken
    vq.push_back(mk(0,0,3,0,0, 2, 10'd0,          4));
    vq.push_back(mk(0,0,3,0,0, 3, S_ALU|S_PINC,   4));
    vq.push_back(mk(0,1,4,0,0, 1, S_IREQ|S_IRWE,  5)); // JUMP
    vq.push_back(mk(0,0,4,0,0, 2, 10'd0,          5));
    vq.push_back(mk(0,0,4,0,0, 3, S_ALU|S_PLD|S_RFWE, 5));
    vq.push_back(mk(0,0,4,0,1, 1, S_IREQ,         6)); // stray dmem_ack
    vq.push_back(mk(0,1,5,0,0, 1, S_IREQ|S_IRWE,  6)); // HALT
    vq.push_back(mk(0,0,5,0,0, 2, 10'd0,          6));
    vq.push_back(mk(1,0,5,0,0, 6, S_HLT,          6));
    vq.push_back(mk(1,1,5,0,1, 6, S_HLT,          6));

    foreach (vq[i])
      step(vq[i].s, vq[i].ia, vq[i].op, vq[i].bt, vq[i].da,
           vq[i].est, vq[i].estr, vq[i].eret, $sformatf("vec%0d", i));

    // Fetch timeout: imem_req high exactly 16 cycles, then sticky ERROR.
    do_reset();
    step(1,0,0,0,0, 0, 10'd0, 0, "to_idle");
    for (int i = 0; i < 16; i++)
      step(0,0,0,0,0, 1, S_IREQ, 0, $sformatf("to_wait%0d", i));
    for (int i = 0; i < 3; i++)
      step(1,1,0,0,1, 7, S_ERR, 0, $sformatf("to_err%0d", i));

    // Ack on the 16th fetch cycle is still accepted.
    do_reset();
    step(1,0,0,0,0, 0, 10'd0, 0, "late_idle");
    for (int i = 0; i < 15; i++)
      step(0,0,0,0,0, 1, S_IREQ, 0, $sformatf("late_wait%0d", i));
    step(0,1,0,0,0, 1, S_IREQ|S_IRWE, 0, "late_ack");
    step(0,0,0,0,0, 2, 10'd0, 0, "late_decode");

    // Data-memory timeout on a LOAD.
    do_reset();
    step(1,0,0,0,0, 0, 10'd0, 0, "dto_idle");
    step(0,1,1,0,0, 1, S_IREQ|S_IRWE, 0, "dto_fetch");
    step(0,0,1,0,0, 2, 10'd0, 0, "dto_decode");
    step(0,0,1,0,0, 3, S_ALU, 0, "dto_exec");
    for (int i = 0; i < 16; i++)
      step(0,0,1,0,0, 4, S_DREQ, 0, $sformatf("dto_wait%0d", i));
    step(0,0,1,0,0, 7, S_ERR, 0, "dto_err");

    // Illegal op classes 6 and 7.
    for (int c = 6; c < 8; c++) begin
      do_reset();
      step(1,0,3'(c),0,0, 0, 10'd0, 0, $sformatf("ill%0d_idle", c));
      step(0,1,3'(c),0,0, 1, S_IREQ|S_IRWE, 0, $sformatf("ill%0d_fetch", c));
      step(0,0,3'(c),0,0, 2, 10'd0, 0, $sformatf("ill%0d_decode", c));
      step(1,0,3'(c),0,0, 7, S_ERR, 0, $sformatf("ill%0d_err", c));
    end

    // Reset while a LOAD waits in MEM, after one retired ALU op.
    do_reset();
    step(1,0,0,0,0, 0, 10'd0, 0, "rst_idle");
    step(0,1,0,0,0, 1, S_IREQ|S_IRWE, 0, "rst_alu_fetch");
    step(0,0,0,0,0, 2, 10'd0, 0, "rst_alu_dec");
    step(0,0,0,0,0, 3, S_ALU, 0, "rst_alu_exec");
    step(0,0,0,0,0, 5, S_RFWE|S_PINC, 0, "rst_alu_wb");
    step(0,1,1,0,0, 1, S_IREQ|S_IRWE, 1, "rst_ld_fetch");
    step(0,0,1,0,0, 2, 10'd0, 1, "rst_ld_dec");
    step(0,0,1,0,0, 3, S_ALU, 1, "rst_ld_exec");
    step(0,0,1,0,0, 4, S_DREQ, 1, "rst_ld_mem");
    reset = 1'b1;
    step(0,0,1,0,0, 4, S_DREQ, 1, "rst_edge");
    reset = 1'b0;
    step(0,0,1,0,1, 0, 10'd0, 0, "rst_after");
    step(0,0,1,0,1, 0, 10'd0, 0, "rst_idle_hold");

    // Retired counter saturates at 15 over 20 ALU instructions.
    do_reset();
    step(1,0,0,0,0, 0, 10'd0, 0, "sat_idle");
    for (int i = 0; i < 20; i++) begin
      logic [3:0] r;
      r = (i > 15) ? 4'd15 : 4'(i);
      step(0,1,0,0,0, 1, S_IREQ|S_IRWE, r, $sformatf("sat%0d_fetch", i));
      step(0,0,0,0,0, 2, 10'd0, r, $sformatf("sat%0d_dec", i));
      step(0,0,0,0,0, 3, S_ALU, r, $sformatf("sat%0d_exec", i));
      step(0,0,0,0,0, 5, S_RFWE|S_PINC, r, $sformatf("sat%0d_wb", i));
    end
    step(0,0,0,0,0, 1, S_IREQ, 15, "sat_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
